// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - three-port SDRAM controller arbiter with watchdog
module sdram_arb #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [24:0] addr0,
  input  logic [24:0] addr1,
  input  logic [24:0] addr2,
  input  logic [1:0]  wtbt0,
  input  logic [1:0]  wtbt1,
  input  logic [1:0]  wtbt2,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic [24:0] sdram_addr,
  output logic [1:0]  sdram_wtbt,
  output logic [15:0] sdram_data_i,
  output logic        sdram_rd,
  output logic        sdram_we,
  input  logic [15:0] sdram_data_o,
  input  logic        sdram_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  localparam bit         WD_EN    = (TIMEOUT != 0);
  localparam bit         FIXED    = (FIXED_PRIO != 0);

  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  wd_q, wd_d;
  logic [2:0]  ack_q, ack_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic        busy_q;
  logic [1:0]  grant_q, grant_d;
  logic [24:0] addr_q, addr_d;
  logic [1:0]  wtbt_q, wtbt_d;
  logic [15:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        we_q, we_d;

  logic [1:0]  win;
  logic [24:0] win_addr;
  logic [1:0]  win_wtbt;
  logic [15:0] win_data;
  logic        win_we;

  // Winner selection: fixed priority by index, or round-robin starting after the last winner
  always_comb begin
    win = 2'd0;
    if (FIXED) begin
      if (req[0])      win = 2'd0;
      else if (req[1]) win = 2'd1;
      else             win = 2'd2;
    end else begin
      case (last_q)
        2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  // Route the selected port's request fields toward the controller registers
  always_comb begin
    win_addr = addr2;
    win_wtbt = wtbt2;
    win_data = wdata2;
    win_we   = we[2];
    case (win)
      2'd0: begin
        win_addr = addr0;
        win_wtbt = wtbt0;
        win_data = wdata0;
        win_we   = we[0];
      end
      2'd1: begin
        win_addr = addr1;
        win_wtbt = wtbt1;
        win_data = wdata1;
        win_we   = we[1];
      end
      default: ;
    endcase
  end

  // Next-state and output logic for the IDLE/ACCESS/DONE sequence
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wd_d    = wd_q;
    ack_d   = 3'b000;
    err_d   = 3'b000;
    rdata_d = rdata_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wtbt_d  = wtbt_q;
    data_d  = data_q;
    rd_d    = rd_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          addr_d  = win_addr;
          wtbt_d  = win_wtbt;
          data_d  = win_data;
          we_d    = win_we;
          rd_d    = ~win_we;
          wd_d    = 8'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (sdram_ready) begin
          rd_d  = 1'b0;
          we_d  = 1'b0;
          if (rd_q) rdata_d = sdram_data_o;
          ack_d = 3'b001 << grant_q;
          state_d = DONE;
        end else if (WD_EN && (wd_q == TO_LIMIT)) begin
          rd_d  = 1'b0;
          we_d  = 1'b0;
          err_d = 3'b001 << grant_q;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset forces every strobe low immediately
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      wd_q    <= 8'd0;
      ack_q   <= 3'b000;
      err_q   <= 3'b000;
      rdata_q <= 16'h0000;
      busy_q  <= 1'b0;
      grant_q <= 2'd0;
      addr_q  <= 25'd0;
      wtbt_q  <= 2'd0;
      data_q  <= 16'h0000;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= (state_d != IDLE);
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wtbt_q  <= wtbt_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
    end
  end

  assign ack          = ack_q;
  assign err          = err_q;
  assign rdata        = rdata_q;
  assign busy         = busy_q;
  assign grant_id     = grant_q;
  assign sdram_addr   = addr_q;
  assign sdram_wtbt   = wtbt_q;
  assign sdram_data_i = data_q;
  assign sdram_rd     = rd_q;
  assign sdram_we     = we_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - directed vector bench for the SDRAM arbiter
module tb_sdram_arb;

  logic        CLK;
  logic        RESET_N;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [24:0] addr0, addr1, addr2;
  logic [1:0]  wtbt0, wtbt1, wtbt2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [15:0] sdram_data_o;
  logic        sdram_ready;

  logic [2:0]  ack, err;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  grant_id;
  logic [24:0] sdram_addr;
  logic [1:0]  sdram_wtbt;
  logic [15:0] sdram_data_i;
  logic        sdram_rd, sdram_we;

  logic [2:0]  f_ack, f_err;
  logic [15:0] f_rdata;
  logic        f_busy;
  logic [1:0]  f_grant;
  logic [24:0] f_addr;
  logic [1:0]  f_wtbt;
  logic [15:0] f_data;
  logic        f_rd, f_we;

  sdram_arb #(.FIXED_PRIO(0), .TIMEOUT(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wtbt0(wtbt0), .wtbt1(wtbt1), .wtbt2(wtbt2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .sdram_addr(sdram_addr), .sdram_wtbt(sdram_wtbt), .sdram_data_i(sdram_data_i),
    .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_data_o(sdram_data_o), .sdram_ready(sdram_ready)
  );

  sdram_arb #(.FIXED_PRIO(1), .TIMEOUT(0)) dut_fp (
    .CLK(CLK), .RESET_N(RESET_N), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wtbt0(wtbt0), .wtbt1(wtbt1), .wtbt2(wtbt2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .ack(f_ack), .err(f_err), .rdata(f_rdata), .busy(f_busy), .grant_id(f_grant),
    .sdram_addr(f_addr), .sdram_wtbt(f_wtbt), .sdram_data_i(f_data),
    .sdram_rd(f_rd), .sdram_we(f_we),
    .sdram_data_o(sdram_data_o), .sdram_ready(sdram_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [2:0]  rq;
    int          lat;
    logic [15:0] rdv;
    logic [1:0]  gnt;
    logic [2:0]  exp_ack;
    logic [2:0]  exp_err;
    logic [15:0] exp_rdata;
    bit          gap;
  } vec_t;

  function automatic vec_t mkv(input logic [2:0] rq, input int lat, input logic [15:0] rdv,
                               input logic [1:0] gnt, input logic [2:0] a, input logic [2:0] e,
                               input logic [15:0] rd, input bit gap);
    vec_t v;
    v.rq = rq; v.lat = lat; v.rdv = rdv; v.gnt = gnt;
    v.exp_ack = a; v.exp_err = e; v.exp_rdata = rd; v.gap = gap;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t tbl [NV];

  logic [24:0] p_addr [3];
  logic [1:0]  p_wtbt [3];
  logic [15:0] p_data [3];
  logic        p_we   [3];

  bit got;
  bit hold_ok;
  int scnt;
  int last_ack_cyc;
  logic [1:0] g;

  task automatic wait_main(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (sdram_rd || sdram_we) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fp(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (f_rd || f_we) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic fp_xfer(input logic [1:0] exp_g, input string name);
    bit s;
    wait_fp(s);
    check({name, "_seen"}, s, 1);
    check({name, "_grant"}, f_grant, exp_g);
    sdram_data_o = 16'h1234;
    sdram_ready  = 1'b1;
    @(negedge CLK);
    sdram_ready  = 1'b0;
    check({name, "_ack"}, f_ack, 3'b001 << exp_g);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    p_addr = '{25'h0000AAA, 25'h0000123, 25'h1FFFFFF};
    p_wtbt = '{2'b11, 2'b10, 2'b01};
    p_data = '{16'h1111, 16'h2222, 16'h5555};
    p_we   = '{1'b0, 1'b0, 1'b1};

    tbl[0]  = mkv(3'b111, 1, 16'h0A0A, 2'd0, 3'b001, 3'b000, 16'h0A0A, 0);
    tbl[1]  = mkv(3'b111, 1, 16'h0B0B, 2'd1, 3'b010, 3'b000, 16'h0B0B, 1);
    tbl[2]  = mkv(3'b111, 1, 16'hDEAD, 2'd2, 3'b100, 3'b000, 16'h0B0B, 1);
    tbl[3]  = mkv(3'b111, 1, 16'h0C0C, 2'd0, 3'b001, 3'b000, 16'h0C0C, 1);
    tbl[4]  = mkv(3'b111, 1, 16'h0D0D, 2'd1, 3'b010, 3'b000, 16'h0D0D, 1);
    tbl[5]  = mkv(3'b111, 1, 16'hFFFF, 2'd2, 3'b100, 3'b000, 16'h0D0D, 1);
    tbl[6]  = mkv(3'b010, 4, 16'hBEEF, 2'd1, 3'b010, 3'b000, 16'hBEEF, 0);
    tbl[7]  = mkv(3'b100, 3, 16'h9999, 2'd2, 3'b100, 3'b000, 16'hBEEF, 0);
    tbl[8]  = mkv(3'b001, 0, 16'h0000, 2'd0, 3'b000, 3'b001, 16'hBEEF, 0);
    tbl[9]  = mkv(3'b001, 2, 16'h4321, 2'd0, 3'b001, 3'b000, 16'h4321, 0);
    tbl[10] = mkv(3'b011, 1, 16'h7777, 2'd1, 3'b010, 3'b000, 16'h7777, 0);

    RESET_N = 1'b0;
    req = 3'b000;
    we = 3'b100;
    addr0 = p_addr[0]; addr1 = p_addr[1]; addr2 = p_addr[2];
    wtbt0 = p_wtbt[0]; wtbt1 = p_wtbt[1]; wtbt2 = p_wtbt[2];
    wdata0 = p_data[0]; wdata1 = p_data[1]; wdata2 = p_data[2];
    sdram_data_o = 16'h0000;
    sdram_ready = 1'b0;
    last_ack_cyc = 0;

    repeat (2) @(negedge CLK);
    check("rst_ack_err", {ack, err}, 6'b0);
    check("rst_rdata", rdata, 16'h0000);
    check("rst_busy_grant", {busy, grant_id}, 3'b000);
    check("rst_sdram_addr", sdram_addr, 25'd0);
    check("rst_sdram_misc", {sdram_wtbt, sdram_data_i, sdram_rd, sdram_we}, 20'd0);
    RESET_N = 1'b1;

    sdram_data_o = 16'hAAAA;
    sdram_ready = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_ready_ignored", {ack, err, busy}, 7'b0);
    check("idle_ready_rdata", rdata, 16'h0000);
    sdram_ready = 1'b0;
    sdram_data_o = 16'h0000;

    for (int i = 0; i < NV; i++) begin
      req = tbl[i].rq;
      g = tbl[i].gnt;
      wait_main(got);
      check("grant_seen", got, 1);
      check("grant_id", grant_id, g);
      check("strobe_addr", sdram_addr, p_addr[g]);
      check("strobe_rd_we", {sdram_rd, sdram_we}, {~p_we[g], p_we[g]});
      check("strobe_wtbt_data", {sdram_wtbt, sdram_data_i}, {p_wtbt[g], p_data[g]});
      check("strobe_no_ack", {ack, err}, 6'b0);
      if (tbl[i].lat > 0) begin
        hold_ok = 1'b1;
        for (int c = 1; c < tbl[i].lat; c++) begin
          @(negedge CLK);
          if (!(sdram_rd || sdram_we) || sdram_addr != p_addr[g] ||
              sdram_data_i != p_data[g] || sdram_wtbt != p_wtbt[g] || ack != 3'b000)
            hold_ok = 1'b0;
        end
        check("strobe_hold", hold_ok, 1);
        sdram_data_o = tbl[i].rdv;
        sdram_ready = 1'b1;
        @(negedge CLK);
        sdram_ready = 1'b0;
        sdram_data_o = 16'h0000;
      end else begin
        scnt = 1;
        for (int k = 0; k < 20; k++) begin
          @(negedge CLK);
          if (ack != 3'b000 || err != 3'b000) break;
          if (sdram_rd || sdram_we) scnt++;
        end
        check("wd_strobe_cycles", scnt, 5);
        check("fp_wd_disabled", {f_err, f_rd}, 4'b0001);
      end
      check("ack", ack, tbl[i].exp_ack);
      check("err", err, tbl[i].exp_err);
      check("strobe_drop", {sdram_rd, sdram_we}, 2'b00);
      check("rdata", rdata, tbl[i].exp_rdata);
      check("busy_done", busy, 1);
      if (tbl[i].gap) check("ack_gap", cyc - last_ack_cyc, 3);
      last_ack_cyc = cyc;
    end
    req = 3'b000;
    repeat (3) @(negedge CLK);

    // fixed priority: port 0 wins while it keeps requesting; port 2 served once 0 drops
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    req = 3'b101;
    fp_xfer(2'd0, "fp_first");
    fp_xfer(2'd0, "fp_again");
    req = 3'b100;
    fp_xfer(2'd2, "fp_port2");
    req = 3'b110;
    fp_xfer(2'd1, "fp_port1");
    req = 3'b000;
    repeat (3) @(negedge CLK);

    // reset during ACCESS: strobes drop at once and round-robin pointer returns to port 0
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    req = 3'b001;
    wait_main(got);
    check("rst_seq_grant0", {got, grant_id}, 3'b100);
    sdram_ready = 1'b1;
    @(negedge CLK);
    sdram_ready = 1'b0;
    check("rst_seq_ack0", ack, 3'b001);
    req = 3'b011;
    wait_main(got);
    check("rst_seq_grant1", {got, grant_id}, 3'b101);
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("rst_mid_strobes", {sdram_rd, sdram_we}, 2'b00);
    check("rst_mid_ack_err", {ack, err}, 6'b0);
    check("rst_mid_busy", busy, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_main(got);
    check("rst_after_grant", {got, grant_id}, 3'b100);
    check("rst_after_addr", sdram_addr, p_addr[0]);
    sdram_ready = 1'b1;
    @(negedge CLK);
    sdram_ready = 1'b0;
    req = 3'b000;
    check("rst_after_ack", {ack, err}, 6'b001000);
    repeat (3) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Three-port arbiter that shares the single SDRAM controller port (addr/wtbt/data/rd/we/ready) between requesters: CPU, video fetch, and the SDRAM test engine. It accepts one word-wide request at a time, selects a winner by round-robin or fixed priority, and drives the controller strobes until `sdram_ready`. It then returns read data and a one-cycle acknowledge to the winner. A watchdog aborts transfers the controller never completes.

## Interface
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = fixed priority, port 0 highest, then 1, then 2.
- `TIMEOUT`, 255: max cycles waiting for `sdram_ready` before abort; 8-bit counter; 0 disables the watchdog.
- `CLK` in 1: clock, all logic on rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `req[2:0]` in 3: per-port request, level, held until that port's ack/err.
- `we[2:0]` in 3: per-port write (1) / read (0).
- `addr0/addr1/addr2` in 25 each: word address.
- `wtbt0/wtbt1/wtbt2` in 2 each: byte enables.
- `wdata0/wdata1/wdata2` in 16 each: write data.
- `ack[2:0]` out 3: one-cycle completion pulse.
- `err[2:0]` out 3: one-cycle timeout pulse (mutually exclusive with ack).
- `rdata` out 16: read data, shared by all ports, valid in the ack cycle, held until the next read completes.
- `busy` out 1: high when not IDLE.
- `grant_id` out 2: current/last winner index.
- `sdram_addr` out 25, `sdram_wtbt` out 2, `sdram_data_i` out 16, `sdram_rd` out 1, `sdram_we` out 1: controller request.
- `sdram_data_o` in 16, `sdram_ready` in 1: controller response.

## Operation
- FSM: IDLE, ACCESS, DONE.
- **IDLE.** If any `req` bit is set, pick a winner.
  - Round-robin: search starts at `(last+1) mod 3`.
  - Fixed priority: lowest index wins.
- **Latching the winner.** Register the winner's addr, wtbt and wdata into the `sdram_*` outputs, and set `grant_id`.
  - Winner write: assert `sdram_we`. Winner read: assert `sdram_rd`.
  - Clear the watchdog and go to ACCESS.
- **ACCESS.** Hold all `sdram_*` outputs constant and count cycles.
  - On `sdram_ready`: deassert rd/we. For a read, capture `sdram_data_o` into `rdata`. Pulse `ack[grant_id]`, then go to DONE.
  - Else, if `TIMEOUT != 0` and count == TIMEOUT: deassert rd/we, pulse `err[grant_id]`, then go to DONE.
- **DONE.** One turnaround cycle; update `last <= grant_id`; go to IDLE.
  - A requester must drop `req` in the cycle after ack/err, or it re-requests.
- **Request stability.** Requests are sampled only in IDLE. Changes to `addr`/`we`/`wdata` after grant have no effect.
- **Reset.**
  - All outputs 0, state IDLE, `last` = 2 (so round-robin favours port 0 first), watchdog 0.
  - Asserting reset mid-ACCESS drops rd/we asynchronously. No ack or err is issued.

## Timing
- Edge N: IDLE samples `req`. `sdram_rd`/`we` are high from edge N+1.
- Ready seen at edge M: ack/err is high and rd/we are low in cycle M+1 (DONE entry).
- Back in IDLE at M+2, so the next grant strobe is high at M+3 at the earliest.
- Minimum request-to-ack is 2 cycles with ready high immediately. Peak throughput is one transfer per 3 cycles + controller latency.
- `sdram_ready` is ignored outside ACCESS.
- Watchdog: err fires TIMEOUT+1 cycles after the strobe rises if ready never arrives.
- `busy` = (state != IDLE), registered.

## Test plan
- **Single read.** Port 1 reads 0x0000123 and the controller returns 0xBEEF after 4 cycles. Required:
  - `sdram_rd` is high for exactly 4 cycles with addr 0x0000123.
  - `ack` = 3'b010 and `rdata` = 0xBEEF one cycle after ready.
- **Round-robin fairness.** FIXED_PRIO=0, all three ports request continuously, ready is returned after 1 cycle. Grant order is 0,1,2,0,1,2 and each ack is separated by 3 cycles.
- **Fixed priority.** FIXED_PRIO=1, ports 0 and 2 request together.
  - Port 0 is served first.
  - Port 2 is served only after port 0 drops `req`; port 2 is never starved while port 0 is idle.
- **Write passthrough.** Port 2 writes 0x5555 with wtbt 2'b01 to 0x1FFFFFF.
  - `sdram_we`=1, `sdram_data_i`=0x5555, `sdram_wtbt`=01, addr 0x1FFFFFF, all held until ready.
  - `rdata` is unchanged from its previous value.
- **Timeout.** TIMEOUT=4, ready never asserted. Required:
  - `err[grant]` pulses on the 5th cycle after the strobe.
  - rd/we drop, no ack is issued, and the next request is granted normally.
- **Reset mid-access.** Pull RESET_N low during ACCESS.
  - rd/we/ack/err are 0 immediately; state is IDLE.
  - After release, a pending port-0 request is granted first.
